// File: rtl/uart_host_if_pkg.sv
// uart_host_if_pkg
// Shared definitions for the host-side uart handshake block:
//   - TX / RX handshake state encodings (IDLE=0, REQ=1, REL=2)
//   - width of the per-FSM wait-state timeout counter
//   - default timeout in clk cycles
//   - helper that tells whether a wait-state counter has used up its budget
package uart_host_if_pkg;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_REQ  = 2'd1,
        T_REL  = 2'd2
    } tx_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_REL  = 2'd2
    } rx_state_e;

    localparam int TMO_W           = 16;
    localparam int DEFAULT_TIMEOUT = 65535;

    // The counter holds the number of cycles already spent in the wait
    // state, so the state is left after exactly 'limit' cycles.
    function automatic logic tmo_expired(input logic [TMO_W-1:0] cnt,
                                         input int               limit);
        return cnt == TMO_W'(limit - 1);
    endfunction

endpackage

// File: rtl/uart_host_if_sync2.sv
// uart_host_if_sync2
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk      - destination clock
//   reset_n  - asynchronous active-low reset; both flops load RESET_VAL
//   d        - asynchronous input
//   q        - synchronized output (two clk of latency)
module uart_host_if_sync2
    import uart_host_if_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_reg <= RESET_VAL;
            q        <= RESET_VAL;
        end else begin
            meta_reg <= d;
            q        <= meta_reg;
        end
    end

endmodule

// File: rtl/uart_host_if.sv
// uart_host_if
// Host-side initiator of the uart req/ack byte handshake. Host writes go
// through a small TX FIFO and are handed to the uart one byte per
// four-phase handshake; received bytes are pulled from the uart into a
// one-entry holding register read by the host with valid/ready.
// Ports:
//   clk, reset_n            - system clock, asynchronous active-low reset
//   wr_valid/wr_data/wr_ready - host TX byte stream into the FIFO
//   rd_valid/rd_data/rd_ready - host RX byte stream out of the holding reg
//   tx_req/tx_data          - request and byte to the uart transmitter
//   tx_ack, tx_empty        - uart transmitter status (asynchronous)
//   rx_req                  - request to the uart receiver
//   rx_ack, rx_empty        - uart receiver status (asynchronous)
//   rx_data                 - uart received byte (quasi-static)
//   tx_count                - TX FIFO occupancy
//   err_timeout             - sticky wait-state timeout flag
module uart_host_if
    import uart_host_if_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        wr_valid,
    input  logic [7:0]                  wr_data,
    output logic                        wr_ready,
    output logic                        rd_valid,
    output logic [7:0]                  rd_data,
    input  logic                        rd_ready,
    output logic                        tx_req,
    output logic [7:0]                  tx_data,
    input  logic                        tx_ack,
    input  logic                        tx_empty,
    output logic                        rx_req,
    input  logic                        rx_ack,
    input  logic                        rx_empty,
    input  logic [7:0]                  rx_data,
    output logic [$clog2(FIFO_DEPTH):0] tx_count,
    output logic                        err_timeout
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // ------------------------------------------------------------------
    // Synchronizers. Bit order {rx_empty, rx_ack, tx_empty, tx_ack};
    // acks reset low, empties reset high so nothing starts before the
    // uart has really been observed.
    // ------------------------------------------------------------------
    localparam logic [3:0] SYNC_RST = 4'b1010;

    logic [3:0] async_in;
    logic [3:0] sync_out;
    logic       tx_ack_s, tx_empty_s, rx_ack_s, rx_empty_s;

    assign async_in = {rx_empty, rx_ack, tx_empty, tx_ack};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            uart_host_if_sync2 #(
                .RESET_VAL (SYNC_RST[gi])
            ) u_sync (
                .clk     (clk),
                .reset_n (reset_n),
                .d       (async_in[gi]),
                .q       (sync_out[gi])
            );
        end
    endgenerate

    assign tx_ack_s   = sync_out[0];
    assign tx_empty_s = sync_out[1];
    assign rx_ack_s   = sync_out[2];
    assign rx_empty_s = sync_out[3];

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          push, pop;

    assign wr_ready = (count_reg != CW'(FIFO_DEPTH));
    assign push     = wr_valid & wr_ready;
    assign tx_count = count_reg;
    // Head stays put until the handshake completes, so tx_data is stable
    // for the whole time tx_req is high.
    assign tx_data  = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX handshake FSM
    // ------------------------------------------------------------------
    tx_state_e        tx_state_reg;
    logic             tx_req_reg;
    logic [TMO_W-1:0] tx_tmo_reg;
    logic             tx_tmo_hit, tx_abort;

    assign tx_tmo_hit = tmo_expired(tx_tmo_reg, TIMEOUT);
    assign tx_req     = tx_req_reg;

    always_comb begin
        // Completed handshake pops; a timed-out one leaves the head in place.
        pop      = (tx_state_reg == T_REL) && !tx_ack_s;
        tx_abort = tx_tmo_hit &&
                   (((tx_state_reg == T_REQ) && !tx_ack_s) ||
                    ((tx_state_reg == T_REL) &&  tx_ack_s));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_reg <= T_IDLE;
            tx_req_reg   <= 1'b0;
            tx_tmo_reg   <= '0;
        end else begin
            case (tx_state_reg)
                T_IDLE: begin
                    tx_tmo_reg <= '0;
                    // Wait for the uart to drain its own buffer first.
                    if ((count_reg != '0) && tx_empty_s) begin
                        tx_state_reg <= T_REQ;
                        tx_req_reg   <= 1'b1;
                    end
                end
                T_REQ: begin
                    if (tx_ack_s || tx_tmo_hit) begin
                        tx_state_reg <= tx_ack_s ? T_REL : T_IDLE;
                        tx_req_reg   <= 1'b0;
                        tx_tmo_reg   <= '0;
                    end else begin
                        tx_tmo_reg   <= tx_tmo_reg + TMO_W'(1);
                    end
                end
                T_REL: begin
                    if (!tx_ack_s || tx_tmo_hit) begin
                        tx_state_reg <= T_IDLE;
                        tx_tmo_reg   <= '0;
                    end else begin
                        tx_tmo_reg   <= tx_tmo_reg + TMO_W'(1);
                    end
                end
                default: begin
                    tx_state_reg <= T_IDLE;
                    tx_req_reg   <= 1'b0;
                    tx_tmo_reg   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX handshake FSM and host holding register
    // ------------------------------------------------------------------
    rx_state_e        rx_state_reg;
    logic             rx_req_reg;
    logic [TMO_W-1:0] rx_tmo_reg;
    logic             rx_tmo_hit, rx_abort;
    logic             rd_valid_reg;
    logic [7:0]       rd_data_reg;

    assign rx_tmo_hit = tmo_expired(rx_tmo_reg, TIMEOUT);
    assign rx_req     = rx_req_reg;
    assign rd_valid   = rd_valid_reg;
    assign rd_data    = rd_data_reg;

    always_comb begin
        rx_abort = rx_tmo_hit &&
                   (((rx_state_reg == R_REQ) && !rx_ack_s) ||
                    ((rx_state_reg == R_REL) &&  rx_ack_s));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_reg <= R_IDLE;
            rx_req_reg   <= 1'b0;
            rx_tmo_reg   <= '0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            // Host consumption never collides with a capture: a request is
            // only issued while the holding register is empty.
            if (rd_valid_reg && rd_ready) begin
                rd_valid_reg <= 1'b0;
            end
            case (rx_state_reg)
                R_IDLE: begin
                    rx_tmo_reg <= '0;
                    if (!rx_empty_s && !rd_valid_reg) begin
                        rx_state_reg <= R_REQ;
                        rx_req_reg   <= 1'b1;
                    end
                end
                R_REQ: begin
                    if (rx_ack_s || rx_tmo_hit) begin
                        rx_state_reg <= rx_ack_s ? R_REL : R_IDLE;
                        rx_req_reg   <= 1'b0;
                        rx_tmo_reg   <= '0;
                    end else begin
                        rx_tmo_reg   <= rx_tmo_reg + TMO_W'(1);
                    end
                end
                R_REL: begin
                    if (!rx_ack_s) begin
                        // The uart settles rx_data as it leaves its ack
                        // state, so sample only after ack has fallen.
                        rx_state_reg <= R_IDLE;
                        rx_tmo_reg   <= '0;
                        rd_data_reg  <= rx_data;
                        rd_valid_reg <= 1'b1;
                    end else if (rx_tmo_hit) begin
                        rx_state_reg <= R_IDLE;
                        rx_tmo_reg   <= '0;
                    end else begin
                        rx_tmo_reg   <= rx_tmo_reg + TMO_W'(1);
                    end
                end
                default: begin
                    rx_state_reg <= R_IDLE;
                    rx_req_reg   <= 1'b0;
                    rx_tmo_reg   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky timeout flag, cleared only by reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_timeout <= 1'b0;
        end else if (tx_abort || rx_abort) begin
            err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_host_if.sv
// tb_uart_host_if
// Directed bench for uart_host_if with a behavioural uart slave that acks
// two clk after a request and releases two clk after the request drops.
module tb_uart_host_if;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready = 1'b0;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_ack = 1'b0;
    logic       tx_empty = 1'b1;
    logic       rx_req;
    logic       rx_ack = 1'b0;
    logic       rx_empty = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic [2:0] tx_count;
    logic       err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave state
    bit         tx_ack_hold = 1'b0;
    int         tx_cnt = 0, rx_cnt = 0;
    int         tx_pulses = 0, rx_pulses = 0;
    logic       tx_req_prev = 1'b0, rx_req_prev = 1'b0;
    logic [7:0] tx_seen [$];
    int         rx_push_cnt = 0, rx_push_seen = 0;
    logic [7:0] rx_load_byte = 8'h00;

    uart_host_if #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .tx_req      (tx_req),
        .tx_data     (tx_data),
        .tx_ack      (tx_ack),
        .tx_empty    (tx_empty),
        .rx_req      (rx_req),
        .rx_ack      (rx_ack),
        .rx_empty    (rx_empty),
        .rx_data     (rx_data),
        .tx_count    (tx_count),
        .err_timeout (err_timeout)
    );

    initial forever #5 clk = ~clk;

    // Behavioural uart slave, reacting on the falling edge.
    always @(negedge clk) begin
        if (rx_push_seen != rx_push_cnt) begin
            rx_push_seen <= rx_push_cnt;
            rx_data      <= rx_load_byte;
            rx_empty     <= 1'b0;
        end
        if (!reset_n) begin
            tx_ack <= 1'b0; rx_ack <= 1'b0;
            tx_cnt <= 0;    rx_cnt <= 0;
            tx_req_prev <= 1'b0; rx_req_prev <= 1'b0;
        end else begin
            tx_req_prev <= tx_req;
            rx_req_prev <= rx_req;
            if (tx_req && !tx_req_prev) tx_pulses <= tx_pulses + 1;
            if (rx_req && !rx_req_prev) rx_pulses <= rx_pulses + 1;
            if (tx_req && !tx_ack && !tx_ack_hold) begin
                if (tx_cnt == 1) begin
                    tx_ack <= 1'b1; tx_cnt <= 0;
                    tx_seen.push_back(tx_data);
                    $display("uart tx byte %02h", tx_data);
                end else tx_cnt <= tx_cnt + 1;
            end else if (!tx_req && tx_ack) begin
                if (tx_cnt == 1) begin tx_ack <= 1'b0; tx_cnt <= 0; end
                else tx_cnt <= tx_cnt + 1;
            end
            if (rx_req && !rx_ack) begin
                if (rx_cnt == 1) begin rx_ack <= 1'b1; rx_cnt <= 0; end
                else rx_cnt <= rx_cnt + 1;
            end else if (!rx_req && rx_ack) begin
                if (rx_cnt == 1) begin
                    rx_ack <= 1'b0; rx_cnt <= 0; rx_empty <= 1'b1;
                end else rx_cnt <= rx_cnt + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; tx_ack_hold = 1'b0;
        wr_valid = 1'b0; rd_ready = 1'b0; tx_empty = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Called on a negedge; returns on the negedge after the byte is taken.
    task automatic write_byte(input logic [7:0] b);
        for (int i = 0; i < 500 && !wr_ready; i++) @(negedge clk);
        wr_valid = 1'b1; wr_data = b;
        @(negedge clk);
        wr_valid = 1'b0;
        $display("host write %02h", b);
    endtask

    task automatic wait_tx_bytes(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_seen.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_rd_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rd_valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++; if (tx_req !== 1'b0) begin n_fail++; $display("FAIL reset_tx_req: got %b want 0", tx_req); end
        n_checks++; if (rx_req !== 1'b0) begin n_fail++; $display("FAIL reset_rx_req: got %b want 0", rx_req); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
        n_checks++; if (tx_count !== 3'd0) begin n_fail++; $display("FAIL reset_tx_count: got %0d want 0", tx_count); end
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_timeout); end
        $display("reset state sampled");
    endtask

    task automatic test_tx_basic();
        int base, p0; bit ok;
        logic [7:0] exp_b;
        do_reset();
        base = tx_seen.size(); p0 = tx_pulses;
        write_byte(8'h41); write_byte(8'h42); write_byte(8'h43);
        n_checks++; if (tx_count !== 3'd3) begin n_fail++; $display("FAIL tx_basic_count3: got %0d want 3", tx_count); end
        wait_tx_bytes(base + 3, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL tx_basic_drain: got %0d bytes want 3", tx_seen.size() - base); end
        repeat (20) @(negedge clk);
        n_checks++; if (tx_count !== 3'd0) begin n_fail++; $display("FAIL tx_basic_count0: got %0d want 0", tx_count); end
        n_checks++; if (tx_pulses - p0 != 3) begin n_fail++; $display("FAIL tx_basic_pulses: got %0d want 3", tx_pulses - p0); end
        for (int i = 0; i < 3; i++) begin
            exp_b = 8'h41 + 8'(i);
            n_checks++;
            if (tx_seen.size() <= base + i || tx_seen[base + i] !== exp_b) begin
                n_fail++; $display("FAIL tx_basic_byte%0d: got %h want %h", i,
                                   (tx_seen.size() > base + i) ? tx_seen[base + i] : 8'hxx, exp_b);
            end
        end
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL tx_basic_err: got %b want 0", err_timeout); end
    endtask

    task automatic test_fifo_full();
        int base, p0; bit ok;
        logic [7:0] exp_b;
        do_reset();
        tx_empty = 1'b0;
        repeat (4) @(negedge clk);
        base = tx_seen.size(); p0 = tx_pulses;
        for (int i = 0; i < 4; i++) write_byte(8'hA0 + 8'(i));
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_wr_ready: got %b want 0", wr_ready); end
        n_checks++; if (tx_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", tx_count); end
        repeat (10) @(negedge clk);
        n_checks++; if (tx_pulses != p0) begin n_fail++; $display("FAIL full_no_req: got %0d pulses want 0", tx_pulses - p0); end
        tx_empty = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_count == 3'd3) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL full_reach3: got %0d want 3", tx_count); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_at3: got %b want 1", wr_ready); end
        write_byte(8'hA4);
        wait_tx_bytes(base + 5, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL full_drain: got %0d bytes want 5", tx_seen.size() - base); end
        for (int i = 0; i < 5; i++) begin
            exp_b = 8'hA0 + 8'(i);
            n_checks++;
            if (tx_seen.size() <= base + i || tx_seen[base + i] !== exp_b) begin
                n_fail++; $display("FAIL full_byte%0d: got %h want %h", i,
                                   (tx_seen.size() > base + i) ? tx_seen[base + i] : 8'hxx, exp_b);
            end
        end
    endtask

    task automatic test_rx();
        int r0; bit ok;
        do_reset();
        r0 = rx_pulses;
        rx_load_byte = 8'h5A; rx_push_cnt++;
        wait_rd_valid(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rx_first_valid: got %b want 1", rd_valid); end
        n_checks++; if (rd_data !== 8'h5A) begin n_fail++; $display("FAIL rx_first_data: got %h want 5a", rd_data); end
        n_checks++; if (rx_pulses - r0 != 1) begin n_fail++; $display("FAIL rx_first_pulses: got %0d want 1", rx_pulses - r0); end
        $display("host read pending %02h", rd_data);
        rx_load_byte = 8'h33; rx_push_cnt++;
        repeat (20) @(negedge clk);
        n_checks++; if (rx_pulses - r0 != 1) begin n_fail++; $display("FAIL rx_blocked_pulses: got %0d want 1", rx_pulses - r0); end
        n_checks++; if (rd_data !== 8'h5A) begin n_fail++; $display("FAIL rx_held_data: got %h want 5a", rd_data); end
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rx_consume: got %b want 0", rd_valid); end
        wait_rd_valid(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rx_second_valid: got %b want 1", rd_valid); end
        n_checks++; if (rd_data !== 8'h33) begin n_fail++; $display("FAIL rx_second_data: got %h want 33", rd_data); end
        n_checks++; if (rx_pulses - r0 != 2) begin n_fail++; $display("FAIL rx_second_pulses: got %0d want 2", rx_pulses - r0); end
        $display("host read %02h", rd_data);
        rd_ready = 1'b1; @(negedge clk); rd_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int hi; bit ok;
        do_reset();
        tx_ack_hold = 1'b1;
        write_byte(8'h99);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tx_req) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL tmo_req_rise: got %b want 1", tx_req); end
        hi = 0;
        while (tx_req && hi < 100) begin hi++; @(negedge clk); end
        n_checks++; if (hi != 8) begin n_fail++; $display("FAIL tmo_req_len: got %0d cycles want 8", hi); end
        n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b want 1", err_timeout); end
        n_checks++; if (tx_count !== 3'd1) begin n_fail++; $display("FAIL tmo_count: got %0d want 1", tx_count); end
        n_checks++; if (tx_data !== 8'h99) begin n_fail++; $display("FAIL tmo_head: got %h want 99", tx_data); end
        $display("timeout after %0d cycles", hi);
    endtask

    task automatic test_reset_mid_rx();
        bit ok;
        do_reset();
        rx_load_byte = 8'h77; rx_push_cnt++;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rx_req) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstrx_req_rise: got %b want 1", rx_req); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (rx_req !== 1'b0) begin n_fail++; $display("FAIL rstrx_req_drop: got %b want 0", rx_req); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rstrx_valid: got %b want 0", rd_valid); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_rd_valid(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstrx_after_valid: got %b want 1", rd_valid); end
        n_checks++; if (rd_data !== 8'h77) begin n_fail++; $display("FAIL rstrx_after_data: got %h want 77", rd_data); end
        $display("host read after reset %02h", rd_data);
        rd_ready = 1'b1; @(negedge clk); rd_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int base; bit ok;
        logic [7:0] exp_b;
        do_reset();
        tx_empty = 1'b0;
        repeat (4) @(negedge clk);
        base = tx_seen.size();
        write_byte(8'h61); write_byte(8'h62);
        tx_empty = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (tx_ack) begin ok = 1'b1; break; end
        end
        for (int i = 0; i < 100 && ok; i++) begin
            @(posedge clk);
            if (!tx_ack) break;
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_ack_seen: got %b want 1", tx_ack); end
        // Ack fell one negedge ago; its synchronized copy reaches the FSM
        // so that the pop lands on the third posedge after the drop.
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (tx_count !== 3'd2) begin n_fail++; $display("FAIL b2b_pre_count: got %0d want 2", tx_count); end
        wr_valid = 1'b1; wr_data = 8'h63;
        @(negedge clk);
        wr_valid = 1'b0;
        $display("host write %02h (with pop)", 8'h63);
        n_checks++; if (tx_count !== 3'd2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", tx_count); end
        write_byte(8'h64); write_byte(8'h65); write_byte(8'h66);
        wait_tx_bytes(base + 6, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_drain: got %0d bytes want 6", tx_seen.size() - base); end
        for (int i = 0; i < 6; i++) begin
            exp_b = 8'h61 + 8'(i);
            n_checks++;
            if (tx_seen.size() <= base + i || tx_seen[base + i] !== exp_b) begin
                n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i,
                                   (tx_seen.size() > base + i) ? tx_seen[base + i] : 8'hxx, exp_b);
            end
        end
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b want 0", err_timeout); end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_fifo_full();
        test_rx();
        test_timeout();
        test_reset_mid_rx();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_host_if.md
Name: uart_host_if

Overview:
- Host-side (CPU/IOT) end of the uart req/ack byte handshake; the initiator that drives tx_req/rx_req and consumes tx_ack/rx_ack/tx_empty/rx_empty/rx_data.
- Buffers host writes in a small TX FIFO and feeds them to the uart one byte per four-phase handshake.
- Polls the uart receive side and unloads each received byte into a one-entry holding register that the host reads with valid/ready.
- All uart-side inputs are treated as asynchronous: the uart runs on its own baud clocks.

Parameters:
- FIFO_DEPTH, 4, TX FIFO entries; power of two, minimum 2.
- TIMEOUT, 65535, clk cycles allowed in any wait state before abort; 16-bit counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- wr_valid  in  1  host offers a TX byte
- wr_data  in  8  TX byte
- wr_ready  out  1  TX FIFO not full
- rd_valid  out  1  RX holding register full
- rd_data  out  8  received byte
- rd_ready  in  1  host consumes rd_data
- tx_req  out  1  to uart tx_req
- tx_ack  in  1  from uart (async)
- tx_empty  in  1  from uart (async)
- rx_req  out  1  to uart rx_req
- rx_ack  in  1  from uart (async)
- rx_empty  in  1  from uart (async)
- rx_data  in  8  from uart; quasi-static, no sync
- tx_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- err_timeout  out  1  sticky; set on any wait-state timeout

Behaviour:
- Reset and clocking:
  - One clock, clk. reset_n is asynchronous and active-low.
  - On reset: tx_req=0, rx_req=0, rd_valid=0, rd_data=0, wr_ready=1, tx_count=0, err_timeout=0, FIFO pointers=0, both FSMs idle.
  - Reset asserted mid-handshake drops the req the same instant; the in-flight FIFO byte is discarded.
- Synchronizers:
  - tx_ack, tx_empty, rx_ack and rx_empty each pass through a 2-flop synchronizer. Reset values: acks 0, empties 1.
  - All FSM decisions use the synchronized copies (_s).
- TX FIFO:
  - A write is accepted when wr_valid & wr_ready.
  - A pop occurs when the TX FSM leaves T_REL.
  - Simultaneous push and pop when full: wr_ready=0, so the push is not taken.
  - Simultaneous push and pop when nonempty: tx_count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM:
  - T_IDLE: if FIFO nonempty & tx_empty_s=1, go to T_REQ.
  - T_REQ: tx_req=1, driving the FIFO head onto the uart tx_data (the head is held stable throughout). On tx_ack_s=1, go to T_REL.
  - T_REL: tx_req=0. On tx_ack_s=0, pop and go to T_IDLE.
  - The tx_empty_s gate keeps the uart from flagging overrun.
  - Minimum 3 clk between handshakes, set by synchronizer latency.
- RX FSM:
  - R_IDLE: if rx_empty_s=0 & rd_valid=0, go to R_REQ.
  - R_REQ: rx_req=1. On rx_ack_s=1, go to R_REL.
  - R_REL: rx_req=0. On rx_ack_s=0, capture rd_data<=rx_data, set rd_valid=1, go to R_IDLE.
  - rx_data is captured only after ack falls, because the uart updates it on the edge leaving its ack-asserting state.
  - rx_empty_s has already risen when rx_ack_s falls, since the synchronizer latencies are equal. This prevents a double request.
- Host read:
  - rd_valid clears on rd_ready & rd_valid.
  - rd_ready with rd_valid=0 is ignored.
  - Clear and new capture in the same cycle cannot occur, because the FSM requests only when rd_valid=0.
- Timeout:
  - Each FSM has its own 16-bit counter, cleared on every state change and counting in T_REQ/T_REL/R_REQ/R_REL.
  - When a counter reaches TIMEOUT: drop the req, set err_timeout, go to idle. TX keeps the FIFO head (no pop); RX captures nothing.
  - err_timeout clears only on reset.

Decomposition:
- Shared package: TX/RX state encodings (2-bit: IDLE=0, REQ=1, REL=2), default TIMEOUT constant.
- One sub-module, sync2: a 2-flop synchronizer with a reset-value parameter, instantiated four times.
- FIFO stays inline.

Test Plan:
- Write 0x41, 0x42, 0x43 back-to-back to a behavioural uart slave (ack 2 clk after req, released 2 clk after req drop) -> exactly three tx_req pulses carrying 0x41, 0x42, 0x43 in order; tx_count 3 -> 0; err_timeout=0.
- Fill the FIFO with 4 writes while tx_empty=0 -> wr_ready=0 after the 4th write, no tx_req. Release tx_empty -> drains in order; a 5th write is accepted once tx_count=3.
- Uart presents rx_data=0x5A and drops rx_empty -> one rx_req handshake, rd_valid=1, rd_data=0x5A. Hold rd_ready=0 with a second byte 0x33 pending -> no rx_req until 0x5A is read, then 0x33 is delivered.
- Hold tx_ack=0 with TIMEOUT=8 -> tx_req drops after 8 cycles in T_REQ, err_timeout=1, byte stays at the FIFO head and tx_count is unchanged.
- Assert reset_n=0 while in R_REQ -> rx_req=0 immediately, rd_valid=0. After release, a fresh handshake completes normally.
- Simultaneous wr_valid with pop at tx_count=2 -> tx_count stays 2, order preserved across pointer wrap (write 6 bytes total, all transmitted in order).
